// File: rtl/sha256_w_pipeline_ctrl.sv
// SHA-256 message-expansion pipeline controller.
// Issues one nonce per cycle into stage 0 and tracks block occupancy with a
// valid shift register. The FSM goes IDLE -> RUN -> DRAIN -> DONE -> IDLE, and
// stall freezes the whole pipeline.
//
// Handshake: there is no ready signal. issue_valid marks a transfer into stage 0
// during the same cycle. stall acts as an inverted ready that holds every stage,
// so while stall is high no block enters, moves or leaves.
module sha256_w_pipeline_ctrl #(
    parameter int STAGES  = 22,
    parameter int NONCE_W = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic               abort,
    input  logic [NONCE_W-1:0] nonce_base,
    input  logic [NONCE_W-1:0] nonce_count,
    input  logic               stall,
    output logic               issue_valid,
    output logic [NONCE_W-1:0] issue_nonce,
    output logic [STAGES-1:0]  stage_en,
    output logic               out_valid,
    output logic [5:0]         inflight,
    output logic               busy,
    output logic               done,
    output logic [1:0]         state_dbg
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [NONCE_W-1:0] NONCE_ONE = NONCE_W'(1);

    logic [1:0]         state;
    logic [NONCE_W-1:0] cur_nonce;
    logic [NONCE_W-1:0] remaining;
    logic [STAGES-1:0]  v;
    logic [STAGES-1:0]  v_next;
    logic [5:0]         pop;

    assign issue_valid = (state == S_RUN) & ~stall;
    assign issue_nonce = cur_nonce;
    assign out_valid   = v[STAGES-1];
    assign inflight    = pop;
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign state_dbg   = state;

    // Next valid vector: shift in the issue bit unless the pipeline is frozen.
    always_comb begin
        v_next = v;
        if (!stall) begin
            v_next = {v[STAGES-2:0], issue_valid};
        end
    end

    // Write enables: a stage is written when a block moves into it or out of it.
    always_comb begin
        stage_en = '0;
        if (!stall) begin
            stage_en[0] = issue_valid | v[0];
            for (int i = 1; i < STAGES; i++) begin
                stage_en[i] = v[i-1] | v[i];
            end
        end
    end

    // Occupancy count of the valid shift register.
    always_comb begin
        pop = '0;
        for (int i = 0; i < STAGES; i++) begin
            pop = pop + 6'(v[i]);
        end
    end

    // Job FSM, nonce/remaining counters and the valid shift register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= S_IDLE;
            v         <= '0;
            cur_nonce <= '0;
            remaining <= '0;
        end else begin
            v <= v_next;
            case (state)
                S_IDLE: begin
                    // Abort is ignored here, so start always wins.
                    if (start) begin
                        if (nonce_count != '0) begin
                            state     <= S_RUN;
                            cur_nonce <= nonce_base;
                            remaining <= nonce_count;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        v         <= '0;
                        remaining <= '0;
                    end else if (issue_valid) begin
                        cur_nonce <= cur_nonce + NONCE_ONE;
                        remaining <= remaining - NONCE_ONE;
                        if (remaining == NONCE_ONE) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        v         <= '0;
                        remaining <= '0;
                    end else if (v_next == '0) begin
                        // Leave on the edge that shifts out the last valid bit.
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    if (abort) begin
                        v         <= '0;
                        remaining <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_w_pipeline_ctrl.sv
// Directed bench for sha256_w_pipeline_ctrl. A job-level model tracks each
// in-flight block by how many unstalled edges it has seen. It is compared with
// the DUT on every falling edge. Literal expectations pin nonces and latencies.
module tb_sha256_w_pipeline_ctrl;

    localparam int S = 22;

    logic          CLK;
    logic          RST;
    logic          start;
    logic          abort;
    logic [31:0]   nonce_base;
    logic [31:0]   nonce_count;
    logic          stall;
    logic          issue_valid;
    logic [31:0]   issue_nonce;
    logic [S-1:0]  stage_en;
    logic          out_valid;
    logic [5:0]    inflight;
    logic          busy;
    logic          done;
    logic [1:0]    state_dbg;

    int n_vec;
    int n_err;
    int cyc;

    // Model: phase 0 idle, 1 run, 2 drain, 3 done; ages of in-flight blocks.
    int          m_phase;
    logic [31:0] m_nonce;
    logic [31:0] m_left;
    int          age_q[$];

    // Observations used by the literal checks.
    logic [31:0] obs_nonce_q[$];
    int          obs_issue_cyc_q[$];
    int          obs_out_cyc_q[$];
    int          obs_done_cyc_q[$];
    logic [31:0] exp_q[$];

    sha256_w_pipeline_ctrl #(.STAGES(S), .NONCE_W(32)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start       (start),
        .abort       (abort),
        .nonce_base  (nonce_base),
        .nonce_count (nonce_count),
        .stall       (stall),
        .issue_valid (issue_valid),
        .issue_nonce (issue_nonce),
        .stage_en    (stage_en),
        .out_valid   (out_valid),
        .inflight    (inflight),
        .busy        (busy),
        .done        (done),
        .state_dbg   (state_dbg)
    );

    // Clock generation.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic a, input logic stl,
                         input logic [31:0] b, input logic [31:0] c);
        start       = s;
        abort       = a;
        stall       = stl;
        nonce_base  = b;
        nonce_count = c;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic clear_obs();
        obs_nonce_q.delete();
        obs_issue_cyc_q.delete();
        obs_out_cyc_q.delete();
        obs_done_cyc_q.delete();
        exp_q.delete();
    endtask

    task automatic check_nonces(input string tag);
        chk({tag, "_n_issued"}, 64'(obs_nonce_q.size()), 64'(exp_q.size()));
        if (obs_nonce_q.size() == exp_q.size()) begin
            foreach (exp_q[k]) chk({tag, "_nonce"}, 64'(obs_nonce_q[k]), 64'(exp_q[k]));
        end
    endtask

    // Scoreboard: compare DUT with the model every cycle, then advance the model.
    logic         e_iss;
    logic [S-1:0] e_en;
    logic [S-1:0] occ;
    always @(negedge CLK) begin
        cyc++;
        if (!RST) begin
            chk("rst_issue_valid", 64'(issue_valid), 64'd0);
            chk("rst_issue_nonce", 64'(issue_nonce), 64'd0);
            chk("rst_stage_en",    64'(stage_en),    64'd0);
            chk("rst_out_valid",   64'(out_valid),   64'd0);
            chk("rst_inflight",    64'(inflight),    64'd0);
            chk("rst_busy",        64'(busy),        64'd0);
            chk("rst_done",        64'(done),        64'd0);
            chk("rst_state",       64'(state_dbg),   64'd0);
            m_phase = 0;
            m_nonce = '0;
            m_left  = '0;
            age_q.delete();
        end else begin
            e_iss = (m_phase == 1) && !stall;
            occ   = '0;
            foreach (age_q[k]) if (age_q[k] >= 1 && age_q[k] <= S) occ[age_q[k]-1] = 1'b1;
            e_en = '0;
            if (!stall) begin
                e_en[0] = e_iss | occ[0];
                for (int i = 1; i < S; i++) e_en[i] = occ[i] | occ[i-1];
            end
            chk("issue_valid", 64'(issue_valid), 64'(e_iss));
            if (e_iss) chk("issue_nonce", 64'(issue_nonce), 64'(m_nonce));
            chk("stage_en",  64'(stage_en),  64'(e_en));
            chk("out_valid", 64'(out_valid), 64'(occ[S-1]));
            chk("inflight",  64'(inflight),  64'(age_q.size()));
            chk("busy",      64'(busy),      64'(m_phase != 0));
            chk("done",      64'(done),      64'(m_phase == 3));
            chk("state",     64'(state_dbg), 64'(m_phase));

            if (issue_valid) begin
                obs_nonce_q.push_back(issue_nonce);
                obs_issue_cyc_q.push_back(cyc);
            end
            if (out_valid) obs_out_cyc_q.push_back(cyc);
            if (done) obs_done_cyc_q.push_back(cyc);

            if (abort && m_phase != 0) begin
                m_phase = 0;
                m_left  = '0;
                age_q.delete();
            end else begin
                if (!stall) begin
                    foreach (age_q[k]) age_q[k]++;
                    while (age_q.size() > 0 && age_q[0] > S) void'(age_q.pop_front());
                    if (e_iss) age_q.push_back(1);
                end
                case (m_phase)
                    0: if (start) begin
                        if (nonce_count != 0) begin
                            m_phase = 1;
                            m_nonce = nonce_base;
                            m_left  = nonce_count;
                        end else begin
                            m_phase = 3;
                        end
                    end
                    1: if (e_iss) begin
                        m_nonce = m_nonce + 32'd1;
                        if (m_left == 32'd1) m_phase = 2;
                        m_left = m_left - 32'd1;
                    end
                    2: if (age_q.size() == 0) m_phase = 3;
                    default: m_phase = 0;
                endcase
            end
        end
    end

    // Directed stimulus with literal expectations.
    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        RST   = 1'b0;
        start = 1'b0; abort = 1'b0; stall = 1'b0;
        nonce_base = '0; nonce_count = '0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        idle(2);

        // Basic job: three consecutive nonces, 22-edge latency.
        clear_obs();
        drive(1'b1, 1'b0, 1'b0, 32'h100, 32'd3);
        idle(30);
        exp_q.push_back(32'h100); exp_q.push_back(32'h101); exp_q.push_back(32'h102);
        check_nonces("t1");
        chk("t1_consecutive", 64'(obs_issue_cyc_q[2] - obs_issue_cyc_q[0]), 64'd2);
        chk("t1_latency", 64'(obs_out_cyc_q[0] - obs_issue_cyc_q[0]), 64'd22);
        chk("t1_out_cycles", 64'(obs_out_cyc_q.size()), 64'd3);
        chk("t1_done_count", 64'(obs_done_cyc_q.size()), 64'd1);
        chk("t1_done_gap", 64'(obs_done_cyc_q[0] - obs_out_cyc_q[2]), 64'd1);

        // Nonce wrap, with a start mid-RUN that must be ignored.
        clear_obs();
        drive(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'd4);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h999, 32'd9);
        idle(30);
        exp_q.push_back(32'hFFFF_FFFE); exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'h0);         exp_q.push_back(32'h1);
        check_nonces("t2");

        // Stall after the second issue, then a stall during DRAIN.
        clear_obs();
        drive(1'b1, 1'b0, 1'b0, 32'h55, 32'd5);
        idle(2);
        repeat (3) begin
            start = 1'b0; abort = 1'b0; stall = 1'b1;
            #1;
            chk("t3_stall_issue", 64'(issue_valid), 64'd0);
            chk("t3_stall_en", 64'(stage_en), 64'd0);
            chk("t3_stall_inflight", 64'(inflight), 64'd2);
            @(posedge CLK);
            #1;
        end
        idle(8);
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        idle(30);
        for (int k = 0; k < 5; k++) exp_q.push_back(32'h55 + 32'(k));
        check_nonces("t3");
        chk("t3_latency", 64'(obs_out_cyc_q[0] - obs_issue_cyc_q[0]), 64'd27);
        chk("t3_done_count", 64'(obs_done_cyc_q.size()), 64'd1);

        // Zero-length job goes straight to DONE.
        clear_obs();
        drive(1'b1, 1'b0, 1'b0, 32'h7, 32'd0);
        chk("t4_busy", 64'(busy), 64'd1);
        chk("t4_done", 64'(done), 64'd1);
        idle(1);
        chk("t4_busy_after", 64'(busy), 64'd0);
        idle(2);
        chk("t4_no_issue", 64'(obs_nonce_q.size()), 64'd0);
        chk("t4_done_count", 64'(obs_done_cyc_q.size()), 64'd1);

        // Start and abort together in IDLE: start wins.
        clear_obs();
        drive(1'b1, 1'b1, 1'b0, 32'h10, 32'd2);
        idle(28);
        exp_q.push_back(32'h10); exp_q.push_back(32'h11);
        check_nonces("t5");
        chk("t5_done_count", 64'(obs_done_cyc_q.size()), 64'd1);

        // Abort together with stall in RUN: abort wins.
        clear_obs();
        drive(1'b1, 1'b0, 1'b0, 32'h20, 32'd6);
        idle(2);
        drive(1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_inflight", 64'(inflight), 64'd0);
        idle(26);
        chk("t6_issued", 64'(obs_nonce_q.size()), 64'd2);
        chk("t6_no_done", 64'(obs_done_cyc_q.size()), 64'd0);

        // Abort in DRAIN with seven blocks in flight, then an immediate new job.
        clear_obs();
        drive(1'b1, 1'b0, 1'b0, 32'h200, 32'd7);
        idle(7);
        chk("t7_inflight", 64'(inflight), 64'd7);
        chk("t7_drain", 64'(state_dbg), 64'd2);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        chk("t7_idle", 64'(busy), 64'd0);
        chk("t7_inflight0", 64'(inflight), 64'd0);
        chk("t7_out0", 64'(out_valid), 64'd0);
        chk("t7_no_done", 64'(obs_done_cyc_q.size()), 64'd0);
        drive(1'b1, 1'b0, 1'b0, 32'h300, 32'd2);
        chk("t7_restart", 64'(busy), 64'd1);
        idle(28);
        for (int k = 0; k < 7; k++) exp_q.push_back(32'h200 + 32'(k));
        exp_q.push_back(32'h300); exp_q.push_back(32'h301);
        check_nonces("t7");
        chk("t7_done_count", 64'(obs_done_cyc_q.size()), 64'd1);

        // Asynchronous reset in the middle of RUN.
        clear_obs();
        drive(1'b1, 1'b0, 1'b0, 32'h400, 32'd10);
        idle(3);
        RST = 1'b0;
        #1;
        chk("t8_issue_valid", 64'(issue_valid), 64'd0);
        chk("t8_issue_nonce", 64'(issue_nonce), 64'd0);
        chk("t8_stage_en", 64'(stage_en), 64'd0);
        chk("t8_out_valid", 64'(out_valid), 64'd0);
        chk("t8_inflight", 64'(inflight), 64'd0);
        chk("t8_busy", 64'(busy), 64'd0);
        chk("t8_done", 64'(done), 64'd0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        obs_done_cyc_q.delete();
        idle(30);
        chk("t8_idle_after", 64'(busy), 64'd0);
        chk("t8_no_done", 64'(obs_done_cyc_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
